// File: rtl/wb_retire_driver_if.sv
// Writeback retire bus: retiring entries in on a valid/ready handshake, and
// the registered register/segment-file writeback port set out.
interface wb_retire_driver_if #(
  parameter int CNT_W = 3
);
  logic             flush;
  logic             wb_hold;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_data1, in_data2, in_data3, in_data4;
  logic [15:0]      in_segdata1, in_segdata2, in_segdata3, in_segdata4;
  logic [2:0]       in_addr1, in_addr2, in_addr3, in_addr4;
  logic [2:0]       in_segaddr1, in_segaddr2, in_segaddr3, in_segaddr4;
  logic [1:0]       in_opsize;
  logic [3:0]       in_regld;
  logic [3:0]       in_segld;
  logic [6:0]       in_ptcid;
  logic [63:0]      wb_data1, wb_data2, wb_data3, wb_data4;
  logic [15:0]      wb_segdata1, wb_segdata2, wb_segdata3, wb_segdata4;
  logic [2:0]       wb_addr1, wb_addr2, wb_addr3, wb_addr4;
  logic [2:0]       wb_segaddr1, wb_segaddr2, wb_segaddr3, wb_segaddr4;
  logic [1:0]       wb_opsize;
  logic [3:0]       wb_regld;
  logic [3:0]       wb_segld;
  logic [6:0]       wb_inst_ptcid;
  logic             wb_valid;
  logic [CNT_W-1:0] occ_count;

  modport master (
    output flush, wb_hold, in_valid,
    output in_data1, in_data2, in_data3, in_data4,
    output in_segdata1, in_segdata2, in_segdata3, in_segdata4,
    output in_addr1, in_addr2, in_addr3, in_addr4,
    output in_segaddr1, in_segaddr2, in_segaddr3, in_segaddr4,
    output in_opsize, in_regld, in_segld, in_ptcid,
    input  in_ready,
    input  wb_data1, wb_data2, wb_data3, wb_data4,
    input  wb_segdata1, wb_segdata2, wb_segdata3, wb_segdata4,
    input  wb_addr1, wb_addr2, wb_addr3, wb_addr4,
    input  wb_segaddr1, wb_segaddr2, wb_segaddr3, wb_segaddr4,
    input  wb_opsize, wb_regld, wb_segld, wb_inst_ptcid, wb_valid, occ_count
  );

  modport slave (
    input  flush, wb_hold, in_valid,
    input  in_data1, in_data2, in_data3, in_data4,
    input  in_segdata1, in_segdata2, in_segdata3, in_segdata4,
    input  in_addr1, in_addr2, in_addr3, in_addr4,
    input  in_segaddr1, in_segaddr2, in_segaddr3, in_segaddr4,
    input  in_opsize, in_regld, in_segld, in_ptcid,
    output in_ready,
    output wb_data1, wb_data2, wb_data3, wb_data4,
    output wb_segdata1, wb_segdata2, wb_segdata3, wb_segdata4,
    output wb_addr1, wb_addr2, wb_addr3, wb_addr4,
    output wb_segaddr1, wb_segaddr2, wb_segaddr3, wb_segaddr4,
    output wb_opsize, wb_regld, wb_segld, wb_inst_ptcid, wb_valid, occ_count
  );
endinterface

// File: rtl/wb_retire_driver.sv
// In-order retire FIFO feeding the register/segment-file writeback ports,
// one entry per cycle, with same-address collisions resolved at push time.
module wb_retire_driver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic               clk,
  input logic               clr,
  wb_retire_driver_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [6:0]       ptcid;
    logic [1:0]       opsize;
    logic [3:0]       regld;
    logic [3:0]       segld;
    logic [3:0][63:0] data;
    logic [3:0][15:0] segdata;
    logic [3:0][2:0]  addr;
    logic [3:0][2:0]  segaddr;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           in_ent;
  entry_t           head_ent;
  entry_t           wb_q;
  logic             wb_valid_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [3:0][2:0]  in_addr, in_segaddr;
  logic [3:0]       regld_masked, segld_masked;
  logic             push, pop;

  assign in_addr    = {bus.in_addr4, bus.in_addr3, bus.in_addr2, bus.in_addr1};
  assign in_segaddr = {bus.in_segaddr4, bus.in_segaddr3, bus.in_segaddr2, bus.in_segaddr1};

  // A lower slot drops its enable when any higher enabled slot targets the same address.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mask
      logic reg_hit, seg_hit;
      always_comb begin
        reg_hit = 1'b0;
        seg_hit = 1'b0;
        for (int j = gi + 1; j < 4; j++) begin
          if (bus.in_regld[j] && (in_addr[j] == in_addr[gi]))       reg_hit = 1'b1;
          if (bus.in_segld[j] && (in_segaddr[j] == in_segaddr[gi])) seg_hit = 1'b1;
        end
      end
      assign regld_masked[gi] = bus.in_regld[gi] & ~reg_hit;
      assign segld_masked[gi] = bus.in_segld[gi] & ~seg_hit;
    end
  endgenerate

  always_comb begin
    in_ent         = '0;
    in_ent.ptcid   = bus.in_ptcid;
    in_ent.opsize  = bus.in_opsize;
    in_ent.regld   = regld_masked;
    in_ent.segld   = segld_masked;
    in_ent.data    = {bus.in_data4, bus.in_data3, bus.in_data2, bus.in_data1};
    in_ent.segdata = {bus.in_segdata4, bus.in_segdata3, bus.in_segdata2, bus.in_segdata1};
    in_ent.addr    = in_addr;
    in_ent.segaddr = in_segaddr;
  end

  assign bus.in_ready = (occ_q != CNT_W'(DEPTH));
  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop  = !bus.flush && !bus.wb_hold && (occ_q != '0);
  assign head_ent = mem[rd_ptr_q];

  always_comb begin
    occ_d = occ_q;
    if (bus.flush)        occ_d = '0;
    else if (push && !pop) occ_d = occ_q + CNT_W'(1);
    else if (pop && !push) occ_d = occ_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_ent;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      wb_q       <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      if (bus.flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      // Payload registers hold between issues; only the enables return to zero.
      if (pop) begin
        wb_q       <= head_ent;
        wb_valid_q <= 1'b1;
      end else begin
        wb_q.regld <= '0;
        wb_q.segld <= '0;
        wb_valid_q <= 1'b0;
      end
    end
  end

  assign bus.wb_data1      = wb_q.data[0];
  assign bus.wb_data2      = wb_q.data[1];
  assign bus.wb_data3      = wb_q.data[2];
  assign bus.wb_data4      = wb_q.data[3];
  assign bus.wb_segdata1   = wb_q.segdata[0];
  assign bus.wb_segdata2   = wb_q.segdata[1];
  assign bus.wb_segdata3   = wb_q.segdata[2];
  assign bus.wb_segdata4   = wb_q.segdata[3];
  assign bus.wb_addr1      = wb_q.addr[0];
  assign bus.wb_addr2      = wb_q.addr[1];
  assign bus.wb_addr3      = wb_q.addr[2];
  assign bus.wb_addr4      = wb_q.addr[3];
  assign bus.wb_segaddr1   = wb_q.segaddr[0];
  assign bus.wb_segaddr2   = wb_q.segaddr[1];
  assign bus.wb_segaddr3   = wb_q.segaddr[2];
  assign bus.wb_segaddr4   = wb_q.segaddr[3];
  assign bus.wb_opsize     = wb_q.opsize;
  assign bus.wb_regld      = wb_q.regld;
  assign bus.wb_segld      = wb_q.segld;
  assign bus.wb_inst_ptcid = wb_q.ptcid;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.occ_count     = occ_q;
endmodule
